// File: rtl/pbvi_backup_argmax_if.sv
// Bundle of control, operand and output-stream signals for the PBVI backup engine.
// The master drives start/config/operands and out_ready; the slave (engine) drives status and
// the output stream.
interface pbvi_backup_argmax_if #(
    parameter int unsigned N_STATE  = 2,
    parameter int unsigned N_ALPHA  = 16,
    parameter int unsigned N_OBS    = 2,
    parameter int unsigned N_ACTION = 3,
    parameter int unsigned N_BELIEF = 16,
    parameter int unsigned WIDTH    = 16
) ();
    localparam int unsigned CfgW = $clog2(N_ALPHA + 1);
    localparam int unsigned AW   = (N_ACTION > 1) ? $clog2(N_ACTION) : 1;
    localparam int unsigned BW   = (N_BELIEF > 1) ? $clog2(N_BELIEF) : 1;

    logic                                                          en;
    logic [CfgW-1:0]                                               cfg_n_alpha;
    logic [N_ACTION-1:0][N_OBS-1:0][N_ALPHA-1:0][N_STATE-1:0][WIDTH-1:0] gamma_intermediate;
    logic [N_ACTION-1:0][N_STATE-1:0][WIDTH-1:0]                   gamma_reward;
    logic [N_BELIEF-1:0][N_STATE-1:0][WIDTH-1:0]                   point_belief;
    logic                                                          busy;
    logic                                                          out_valid;
    logic                                                          out_ready;
    logic [BW-1:0]                                                 out_belief;
    logic [AW-1:0]                                                 out_action;
    logic [N_STATE-1:0][WIDTH-1:0]                                 out_vec;
    logic                                                          done;

    modport master (
        output en, cfg_n_alpha, gamma_intermediate, gamma_reward, point_belief, out_ready,
        input  busy, out_valid, out_belief, out_action, out_vec, done
    );

    modport slave (
        input  en, cfg_n_alpha, gamma_intermediate, gamma_reward, point_belief, out_ready,
        output busy, out_valid, out_belief, out_action, out_vec, done
    );
endinterface

// File: rtl/pbvi_backup_argmax.sv
// PBVI backup engine: per (belief, action) pair, picks for each observation the intermediate
// alpha vector with the largest dot product against the belief, sums the winners onto the
// action reward vector with saturation, and streams the result out with valid/ready.
// One dot product is evaluated per cycle; the operand arrays are read directly, not registered.
module pbvi_backup_argmax #(
    parameter int unsigned N_STATE  = 2,
    parameter int unsigned N_ALPHA  = 16,
    parameter int unsigned N_OBS    = 2,
    parameter int unsigned N_ACTION = 3,
    parameter int unsigned N_BELIEF = 16,
    parameter int unsigned WIDTH    = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    pbvi_backup_argmax_if.slave bus
);
    localparam int unsigned CfgW = $clog2(N_ALPHA + 1);
    localparam int unsigned JW   = (N_ALPHA > 1) ? $clog2(N_ALPHA) : 1;
    localparam int unsigned OW   = (N_OBS > 1) ? $clog2(N_OBS) : 1;
    localparam int unsigned AW   = (N_ACTION > 1) ? $clog2(N_ACTION) : 1;
    localparam int unsigned BW   = (N_BELIEF > 1) ? $clog2(N_BELIEF) : 1;
    // Full-precision dot product: products are 2*WIDTH bits, plus carry room for the sum.
    localparam int unsigned DotW = 2 * WIDTH + $clog2(N_STATE);

    localparam logic [OW-1:0] OLast = OW'(N_OBS - 1);
    localparam logic [AW-1:0] ALast = AW'(N_ACTION - 1);
    localparam logic [BW-1:0] BLast = BW'(N_BELIEF - 1);

    typedef enum logic [2:0] {StIdle, StScan, StAccum, StEmit, StDone} state_e;

    state_e                        r_state, w_state_nxt;
    logic [BW-1:0]                 r_b, w_b_nxt;
    logic [AW-1:0]                 r_a, w_a_nxt;
    logic [OW-1:0]                 r_o, w_o_nxt;
    logic [JW-1:0]                 r_j, w_j_nxt;
    logic [JW-1:0]                 r_jmax, w_jmax_nxt;
    logic [DotW-1:0]               r_best_dot, w_best_dot_nxt;
    logic [JW-1:0]                 r_best_idx, w_best_idx_nxt;
    logic [N_STATE-1:0][WIDTH-1:0] r_acc, w_acc_nxt;

    logic [DotW-1:0]               w_dot;
    logic [N_STATE-1:0][WIDTH:0]   w_sum;
    logic [N_STATE-1:0][WIDTH-1:0] w_acc_sat;
    logic [JW-1:0]                 w_jmax_cfg;

    // Dot product of the current candidate alpha with the current belief.
    always_comb begin
        w_dot = '0;
        for (int s = 0; s < N_STATE; s++) begin
            w_dot = w_dot + DotW'(bus.gamma_intermediate[r_a][r_o][r_j][s])
                          * DotW'(bus.point_belief[r_b][s]);
        end
    end

    // Accumulator plus winning alpha, clamped at all-ones instead of wrapping.
    always_comb begin
        w_sum     = '0;
        w_acc_sat = '0;
        for (int s = 0; s < N_STATE; s++) begin
            w_sum[s] = {1'b0, r_acc[s]}
                     + {1'b0, bus.gamma_intermediate[r_a][r_o][r_best_idx][s]};
            w_acc_sat[s] = w_sum[s][WIDTH] ? {WIDTH{1'b1}} : w_sum[s][WIDTH-1:0];
        end
    end

    // Last alpha index for the run: 0 means one alpha, oversize values clamp to N_ALPHA.
    always_comb begin
        if (bus.cfg_n_alpha == '0) begin
            w_jmax_cfg = '0;
        end else if (bus.cfg_n_alpha > CfgW'(N_ALPHA)) begin
            w_jmax_cfg = JW'(N_ALPHA - 1);
        end else begin
            w_jmax_cfg = JW'(bus.cfg_n_alpha - 1'b1);
        end
    end

    // Next-state and datapath update for the scan/accumulate/emit sequence.
    always_comb begin
        w_state_nxt    = r_state;
        w_b_nxt        = r_b;
        w_a_nxt        = r_a;
        w_o_nxt        = r_o;
        w_j_nxt        = r_j;
        w_jmax_nxt     = r_jmax;
        w_best_dot_nxt = r_best_dot;
        w_best_idx_nxt = r_best_idx;
        w_acc_nxt      = r_acc;

        unique case (r_state)
            StIdle: begin
                if (bus.en) begin
                    w_state_nxt    = StScan;
                    w_b_nxt        = '0;
                    w_a_nxt        = '0;
                    w_o_nxt        = '0;
                    w_j_nxt        = '0;
                    w_jmax_nxt     = w_jmax_cfg;
                    w_best_dot_nxt = '0;
                    w_best_idx_nxt = '0;
                    w_acc_nxt      = bus.gamma_reward[0];
                end
            end
            StScan: begin
                // Strict compare keeps the lowest index on ties.
                if (r_j == '0 || w_dot > r_best_dot) begin
                    w_best_dot_nxt = w_dot;
                    w_best_idx_nxt = r_j;
                end
                if (r_j == r_jmax) begin
                    w_state_nxt = StAccum;
                end else begin
                    w_j_nxt = r_j + 1'b1;
                end
            end
            StAccum: begin
                w_acc_nxt = w_acc_sat;
                if (r_o == OLast) begin
                    w_state_nxt = StEmit;
                end else begin
                    w_o_nxt     = r_o + 1'b1;
                    w_j_nxt     = '0;
                    w_state_nxt = StScan;
                end
            end
            StEmit: begin
                if (bus.out_ready) begin
                    if (r_a == ALast && r_b == BLast) begin
                        w_state_nxt = StDone;
                    end else begin
                        if (r_a == ALast) begin
                            w_a_nxt = '0;
                            w_b_nxt = r_b + 1'b1;
                        end else begin
                            w_a_nxt = r_a + 1'b1;
                        end
                        w_o_nxt     = '0;
                        w_j_nxt     = '0;
                        w_acc_nxt   = bus.gamma_reward[w_a_nxt];
                        w_state_nxt = StScan;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_b        <= '0;
            r_a        <= '0;
            r_o        <= '0;
            r_j        <= '0;
            r_jmax     <= '0;
            r_best_dot <= '0;
            r_best_idx <= '0;
            r_acc      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_b        <= w_b_nxt;
            r_a        <= w_a_nxt;
            r_o        <= w_o_nxt;
            r_j        <= w_j_nxt;
            r_jmax     <= w_jmax_nxt;
            r_best_dot <= w_best_dot_nxt;
            r_best_idx <= w_best_idx_nxt;
            r_acc      <= w_acc_nxt;
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free and stable in EMIT.
    assign bus.busy       = (r_state != StIdle);
    assign bus.out_valid  = (r_state == StEmit);
    assign bus.done       = (r_state == StDone);
    assign bus.out_belief = r_b;
    assign bus.out_action = r_a;
    assign bus.out_vec    = r_acc;
endmodule

// File: doc/pbvi_backup_argmax.md
# pbvi_backup_argmax

Sequential, parametrised PBVI backup engine. For every belief point and action it finds, per observation, the intermediate alpha vector with the largest dot product against the belief. It then adds the winning vectors to the action reward vector and streams one backed-up alpha vector per (belief, action) pair. It sits between the intermediate-gamma generation stage and the per-belief action selection stage. It time-multiplexes one dot-product unit, supports a runtime-configurable active alpha count, and accepts output backpressure.

## Interface
- N_STATE, 2: states per vector (≥2).
- N_ALPHA, 16: maximum alpha vectors per (action, observation).
- N_OBS, 2: observations.
- N_ACTION, 3: actions.
- N_BELIEF, 16: belief points.
- WIDTH, 16: unsigned fixed-point element width, Q0.WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  start pulse; ignored while busy.
- cfg_n_alpha  in  $clog2(N_ALPHA+1)  active alpha count, sampled on accepted en.
- gamma_intermediate  in  WIDTH [N_ACTION][N_OBS][N_ALPHA][N_STATE]  intermediate alpha vectors.
- gamma_reward  in  WIDTH [N_ACTION][N_STATE]  reward vectors.
- point_belief  in  WIDTH [N_BELIEF][N_STATE]  belief points.
- busy  out  1  high from the cycle after an accepted en until done.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts the output vector.
- out_belief  out  $clog2(N_BELIEF)  belief index of the output vector.
- out_action  out  $clog2(N_ACTION)  action index of the output vector.
- out_vec  out  WIDTH [N_STATE]  backed-up alpha vector.
- done  out  1  one-cycle pulse after the last transfer.

## Operation
- Reset (rst_n=0 at a clock edge) gives: state IDLE, busy=0, out_valid=0, done=0, out_belief=0, out_action=0, out_vec=0, all counters and accumulators 0.
- Reset mid-run aborts the run. No done pulse is produced.
- Inputs are stable from the accepted en until done. They are not registered.
- Active alpha count n is fixed at en:
  - cfg_n_alpha=0 gives n=1.
  - cfg_n_alpha>N_ALPHA gives n=N_ALPHA.
- Loop order, outer to inner: belief b, action a, observation o, alpha j<n.
- IDLE:
  - en=1 moves to SCAN with b=a=o=j=0.
  - The accumulator is loaded with gamma_reward[0].
- SCAN (one alpha per cycle):
  - dot = Σ_s gamma_intermediate[a][o][j][s]·point_belief[b][s], kept at full precision 2·WIDTH+$clog2(N_STATE) bits, with no truncation before compare.
  - j=0 loads best_dot and best_idx unconditionally.
  - For j>0, update only if dot > best_dot. Strict compare, so on a tie the lowest index wins.
  - After j=n-1, go to ACCUM.
- ACCUM (one cycle):
  - acc[s] = sat(acc[s] + gamma_intermediate[a][o][best_idx][s]).
  - sat clamps to 2^WIDTH−1 and never wraps.
  - If o<N_OBS−1: o++, j=0, back to SCAN. Otherwise go to EMIT.
- EMIT:
  - out_valid=1; out_vec=acc; out_belief=b; out_action=a.
  - These hold stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready, advance (a,b), with a inner.
  - If more pairs remain: reload acc with gamma_reward[next a], o=j=0, go to SCAN.
  - After pair (N_BELIEF−1, N_ACTION−1): go to DONE.
- DONE: done=1 for one cycle, busy=0 the next cycle, return to IDLE.
- en during busy has no effect. en in the DONE cycle is ignored. en in IDLE the cycle after DONE is accepted.

## Timing
- Per pair: N_OBS·(n+1) cycles of SCAN/ACCUM, then ≥1 EMIT cycle.
- With out_ready tied high, total from en to done = N_BELIEF·N_ACTION·(N_OBS·(n+1)+1)+1 cycles.
- Defaults with n=16 give 1681 cycles.
- out_valid rises on the edge that enters EMIT. out_valid drops the cycle after the transfer.
- busy rises the cycle after en.

## Test plan
- Basic, defaults, out_ready=1:
  - Stimulus: point_belief[0]=(0x8000,0x8000); for a=0, o=0: alpha0=(0x0100,0x0100), alpha5=(0x0400,0x0000), all others 0; gamma_reward[0]=(0x0010,0x0020).
  - Response: o=0 picks idx 5; o=1 all zeros picks idx 0. First output is b=0, a=0, out_vec=(0x0410,0x0020).
  - done arrives at cycle 1681.
- Tie:
  - Stimulus: alpha0=(0x0100,0x0200), alpha1=(0x0200,0x0100), belief (0x8000,0x8000).
  - Response: idx 0 selected, so the contribution is (0x0100,0x0200).
- Saturation:
  - Stimulus: reward (0xFFF0,0), winning alphas (0x0020,0) for both observations.
  - Response: out_vec[0]=0xFFFF.
- cfg_n_alpha:
  - Stimulus: cfg_n_alpha=4 with a larger alpha at idx 9; also run cfg_n_alpha=0.
  - Response: with 4, idx 9 is never selected and run length is 16·3·(2·5+1)+1=529. With 0, the length is 16·3·5+1=241.
- Backpressure:
  - Stimulus: out_ready low for 7 cycles on the first output; also en pulsed mid-run.
  - Response: out_vec, out_belief, out_action stable throughout; no output lost or duplicated; total count is 48 in order b-major; the mid-run en is ignored.
- Reset mid-run:
  - Stimulus: rst_n=0 during SCAN of pair 10.
  - Response: next cycle busy=0, out_valid=0, no done. A new en then produces the full 48-vector sequence.
